// File: rtl/multiword_add_seq.sv
// ---------------------------------------------------------------------------
// multiword_add_seq
//   Sequential wide adder/subtractor. A TW = W*CHUNKS bit operation is
//   processed W bits per cycle through a single W-bit ripple_carry_adder.
//   The inter-chunk carry is held in a register, so no TW-bit combinational
//   carry chain exists.
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operand request valid
//   in_ready   block can accept an operation (IDLE only)
//   op_a/op_b  TW-bit operands
//   cin        carry-in for add (ignored for subtract)
//   sub        1 = op_a - op_b
//   out_valid  result valid (DONE only)
//   out_ready  consumer accepts the result
//   result     TW-bit sum or difference
//   cout       carry out of the MSB (subtract: 1 = no borrow)
//   overflow   two's-complement signed overflow
// ---------------------------------------------------------------------------

// W-bit ripple-carry adder used as the per-chunk datapath.
module ripple_carry_adder #(
    parameter int unsigned N = 8
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout
);

    logic [N:0] c;

    always_comb begin
        c    = '0;
        sum  = '0;
        c[0] = cin;
        for (int unsigned i = 0; i < N; i++) begin
            sum[i]   = a[i] ^ b[i] ^ c[i];
            c[i+1]   = (a[i] & b[i]) | (a[i] & c[i]) | (b[i] & c[i]);
        end
        cout = c[N];
    end

endmodule

module multiword_add_seq #(
    parameter int unsigned W      = 8,
    parameter int unsigned CHUNKS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [W*CHUNKS-1:0] op_a,
    input  logic [W*CHUNKS-1:0] op_b,
    input  logic                cin,
    input  logic                sub,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [W*CHUNKS-1:0] result,
    output logic                cout,
    output logic                overflow
);

    localparam int unsigned TW = W * CHUNKS;
    // Counter is at least 1 bit wide so CHUNKS = 1 still elaborates.
    localparam int unsigned KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
    localparam logic [KW-1:0] LAST = KW'(CHUNKS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t        state, state_nxt;

    logic [TW-1:0] a_reg;
    logic [TW-1:0] b_reg;    // already inverted for subtract
    logic          carry;
    logic [KW-1:0] cnt;

    logic [W-1:0]  a_chunk;
    logic [W-1:0]  b_chunk;
    logic [W-1:0]  sum_chunk;
    logic          add_cout;

    logic          accept;
    logic          last_chunk;
    logic          ovf_nxt;

    // -----------------------------------------------------------------------
    // Control
    // -----------------------------------------------------------------------
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) state_nxt = RUN;
            end
            RUN: begin
                if (cnt == LAST) state_nxt = DONE;
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept     = (state == IDLE) && in_valid;
    assign last_chunk = (state == RUN) && (cnt == LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // -----------------------------------------------------------------------
    // Chunk selection (constant-index mux keeps part-selects static)
    // -----------------------------------------------------------------------
    always_comb begin
        a_chunk = '0;
        b_chunk = '0;
        for (int unsigned i = 0; i < CHUNKS; i++) begin
            if (cnt == KW'(i)) begin
                a_chunk = a_reg[i*W +: W];
                b_chunk = b_reg[i*W +: W];
            end
        end
    end

    ripple_carry_adder #(
        .N (W)
    ) u_rca (
        .a    (a_chunk),
        .b    (b_chunk),
        .cin  (carry),
        .sum  (sum_chunk),
        .cout (add_cout)
    );

    // Signed overflow: operands agree in sign but the result does not.
    assign ovf_nxt = (a_reg[TW-1] == b_reg[TW-1]) &&
                     (sum_chunk[W-1] != a_reg[TW-1]);

    // -----------------------------------------------------------------------
    // Datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_reg    <= '0;
            b_reg    <= '0;
            carry    <= 1'b0;
            cnt      <= '0;
            result   <= '0;
            cout     <= 1'b0;
            overflow <= 1'b0;
        end else if (accept) begin
            a_reg <= op_a;
            b_reg <= sub ? ~op_b : op_b;
            carry <= sub ? 1'b1 : cin;
            cnt   <= '0;
        end else if (state == RUN) begin
            for (int unsigned i = 0; i < CHUNKS; i++) begin
                if (cnt == KW'(i)) result[i*W +: W] <= sum_chunk;
            end
            carry <= add_cout;
            if (last_chunk) begin
                cout     <= add_cout;
                overflow <= ovf_nxt;
                cnt      <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_multiword_add_seq.sv
// ---------------------------------------------------------------------------
// tb_multiword_add_seq
//   Table-driven directed test of multiword_add_seq (W=8, CHUNKS=4), plus
//   hand-written sequences for backpressure and reset during RUN.
// ---------------------------------------------------------------------------
module tb_multiword_add_seq;

    localparam int unsigned W      = 8;
    localparam int unsigned CHUNKS = 4;
    localparam int unsigned TW     = W * CHUNKS;

    logic          clk;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [TW-1:0] op_a;
    logic [TW-1:0] op_b;
    logic          cin;
    logic          sub;
    logic          out_valid;
    logic          out_ready;
    logic [TW-1:0] result;
    logic          cout;
    logic          overflow;

    int checks   = 0;
    int failures = 0;

    multiword_add_seq #(
        .W      (W),
        .CHUNKS (CHUNKS)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_a      (op_a),
        .op_b      (op_b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .cout      (cout),
        .overflow  (overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [TW-1:0] a;
        logic [TW-1:0] b;
        logic          ci;
        logic          sb;
        logic [TW-1:0] res;
        logic          co;
        logic          ov;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Issue one operation, check handshake/latency and the result.
    // When release_out is set, the result is consumed afterwards.
    task automatic run_op(input vec_t v, input bit release_out);
        int lat;
        @(negedge clk);
        chk("in_ready_idle", {63'd0, in_ready}, 64'd1);
        in_valid = 1'b1;
        op_a     = v.a;
        op_b     = v.b;
        cin      = v.ci;
        sub      = v.sb;
        @(posedge clk);
        @(negedge clk);
        // Inputs may change after the accept edge.
        in_valid = 1'b0;
        op_a     = ~v.a;
        op_b     = ~v.b;
        cin      = ~v.ci;
        sub      = ~v.sb;
        lat = 0;
        while (!out_valid && lat < 20) begin
            chk("in_ready_run", {63'd0, in_ready}, 64'd0);
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        chk("latency", 64'(lat), 64'(CHUNKS));
        chk("result", 64'(result), 64'(v.res));
        chk("cout", {63'd0, cout}, {63'd0, v.co});
        chk("overflow", {63'd0, overflow}, {63'd0, v.ov});
        if (release_out) begin
            out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            out_ready = 1'b0;
            chk("out_valid_drop", {63'd0, out_valid}, 64'd0);
            chk("in_ready_back", {63'd0, in_ready}, 64'd1);
        end
    endtask

    vec_t vecs[10];
    vec_t v_bp;
    vec_t v_after;

    initial begin
        //          a             b             ci    sb    res           co    ov
        vecs[0] = '{32'h000000FF, 32'h00000001, 1'b0, 1'b0, 32'h00000100, 1'b0, 1'b0};
        vecs[1] = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[2] = '{32'hFFFFFFFF, 32'h00000000, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0};
        vecs[3] = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h80000000, 1'b0, 1'b1};
        vecs[4] = '{32'h00000005, 32'h00000007, 1'b0, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[5] = '{32'h80000000, 32'h00000001, 1'b0, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[6] = '{32'h00000005, 32'h00000007, 1'b1, 1'b1, 32'hFFFFFFFE, 1'b0, 1'b0};
        vecs[7] = '{32'h80000000, 32'h00000001, 1'b1, 1'b1, 32'h7FFFFFFF, 1'b1, 1'b1};
        vecs[8] = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b1};
        vecs[9] = '{32'h12345678, 32'h11111111, 1'b0, 1'b0, 32'h23456789, 1'b0, 1'b0};
        v_bp    = '{32'h0000FFFF, 32'h00000001, 1'b1, 1'b0, 32'h00010001, 1'b0, 1'b0};
        v_after = vecs[9];

        rst_n     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        op_a      = '0;
        op_b      = '0;
        cin       = 1'b0;
        sub       = 1'b0;
        #23;
        chk("rst_result", 64'(result), 64'd0);
        chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("rst_cout", {63'd0, cout}, 64'd0);
        chk("rst_overflow", {63'd0, overflow}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 10; i++) run_op(vecs[i], 1'b1);

        // Backpressure: hold result in DONE while offering new operands.
        run_op(v_bp, 1'b0);
        for (int i = 0; i < 5; i++) begin
            in_valid = ~in_valid;
            op_a     = 32'hA5A5A5A5 + 32'(i);
            op_b     = 32'h5A5A5A5A;
            cin      = 1'b1;
            sub      = 1'(i);
            @(posedge clk);
            @(negedge clk);
            chk("bp_out_valid", {63'd0, out_valid}, 64'd1);
            chk("bp_in_ready", {63'd0, in_ready}, 64'd0);
            chk("bp_result", 64'(result), 64'(v_bp.res));
            chk("bp_cout", {63'd0, cout}, {63'd0, v_bp.co});
            chk("bp_overflow", {63'd0, overflow}, {63'd0, v_bp.ov});
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        chk("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
        chk("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
        chk("bp_result_kept", 64'(result), 64'(v_bp.res));
        run_op(vecs[3], 1'b1);

        // Reset after two chunks of an in-flight operation.
        @(negedge clk);
        in_valid = 1'b1;
        op_a     = 32'h12345678;
        op_b     = 32'h11111111;
        cin      = 1'b0;
        sub      = 1'b0;
        @(posedge clk);          // accept
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk);          // chunk 0
        @(posedge clk);          // chunk 1
        #2;
        chk("midrun_partial", 64'(result[15:0]), 64'h6789);
        rst_n = 1'b0;
        #1;
        chk("midrun_rst_result", 64'(result), 64'd0);
        chk("midrun_rst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("midrun_rst_cout", {63'd0, cout}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < CHUNKS + 2; i++) begin
            @(posedge clk);
            @(negedge clk);
            chk("post_rst_no_valid", {63'd0, out_valid}, 64'd0);
            chk("post_rst_in_ready", {63'd0, in_ready}, 64'd1);
        end
        run_op(v_after, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global watchdog so the bench always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/multiword_add_seq.md
Name: multiword_add_seq

Overview:
Sequential wide adder/subtractor. It accepts two operands of W*CHUNKS bits over a valid/ready handshake and processes them W bits per cycle through one internal ripple_carry_adder instance with N = W. The carry ripples between chunks through a register. The block sits directly upstream of the ripple_carry_adder: it sequences chunk operands and the carry into the adder, then collects the adder's sum and cout. It lets the datapath add wide words without a wide combinational carry chain.

Parameters:
W, 8, chunk width; drives N of the internal ripple_carry_adder.
CHUNKS, 4, number of chunks; total operand width is TW = W*CHUNKS; must be >= 1.

Ports:
clk  input  1  rising-edge clock, the only clock.
rst_n  input  1  asynchronous active-low reset.
in_valid  input  1  operand request valid.
in_ready  output  1  block can accept an operation.
op_a  input  TW  operand A.
op_b  input  TW  operand B.
cin  input  1  carry-in for add; ignored when sub=1.
sub  input  1  1 = compute op_a - op_b.
out_valid  output  1  result valid.
out_ready  input  1  consumer accepts the result.
result  output  TW  sum or difference.
cout  output  1  carry out of the MSB; for subtract, 1 = no borrow.
overflow  output  1  two's-complement signed overflow.

Behaviour:
- Reset (async assert, sync-free release):
  - state = IDLE; result, cout, overflow, out_valid = 0; chunk counter = 0; carry register = 0.
  - in_ready = 1 once rst_n is high.
- States and transitions:
  - IDLE: in_ready = 1.
  - RUN: in_ready = 0, out_valid = 0.
  - DONE: in_ready = 0, out_valid = 1.
  - IDLE -> RUN on an in_valid && in_ready edge.
  - RUN -> DONE when the last chunk is registered.
  - DONE -> IDLE on an out_valid && out_ready edge.
- Capture on accept:
  - op_a, op_b, sub are registered.
  - B is registered as ~op_b when sub = 1.
  - Carry register loads 1 if sub = 1, else cin.
  - Chunk counter loads 0.
  - Inputs may change freely after the accept edge.
- RUN, chunk k (k = 0..CHUNKS-1), one per cycle:
  - Adder inputs: a = A[k*W +: W], b = Beff[k*W +: W], cin = carry register.
  - Each edge writes the adder sum into result[k*W +: W], loads the adder cout into the carry register, and increments k.
- Final chunk (k = CHUNKS-1), on the same edge:
  - cout <= adder cout.
  - overflow <= (A[TW-1] == Beff[TW-1]) && (sum MSB != A[TW-1]).
  - State -> DONE.
- Latency: out_valid rises exactly CHUNKS cycles after the accept edge.
- Throughput: at most one operation per CHUNKS+2 cycles. There is no overlap; in_valid in RUN or DONE is ignored.
- Backpressure: in DONE with out_ready = 0, result, cout and overflow hold stable and out_valid stays 1.
- Result visibility: result, cout and overflow are updated only during RUN. Partial result bits during RUN are not valid and are not observed by consumers.
- Output handshake: on the out_valid && out_ready edge, state returns to IDLE. in_ready = 1 in the following cycle; result keeps its value until the next RUN overwrites it.
- Arithmetic: result = (A + Beff + c0) mod 2^TW, where c0 is the initial carry; identical to a single TW-bit adder.
- CHUNKS = 1: latency of 1 cycle; behaviour is otherwise identical.
- Reset mid-operation: any state returns to IDLE immediately; the in-flight operation is discarded and no out_valid is produced.

Test Plan:
- Add with inter-chunk carry: op_a = 0x000000FF, op_b = 0x00000001, cin = 0, sub = 0 -> result = 0x00000100, cout = 0, overflow = 0; out_valid exactly 4 cycles after accept; in_ready = 0 during RUN.
- Full wrap: 0xFFFFFFFF + 0x00000001, cin = 0 -> result = 0x00000000, cout = 1, overflow = 0. Also 0xFFFFFFFF + 0, cin = 1 -> result = 0x00000000, cout = 1.
- Signed overflow: 0x7FFFFFFF + 0x00000001 -> result = 0x80000000, overflow = 1, cout = 0.
- Subtract:
  - 0x00000005 - 0x00000007 -> result = 0xFFFFFFFE, cout = 0, overflow = 0.
  - 0x80000000 - 0x00000001 -> result = 0x7FFFFFFF, cout = 1, overflow = 1.
  - cin = 1 must not affect either result.
- Backpressure and ignored input:
  - Hold out_ready = 0 for 5 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready = 0, no new capture.
  - Then out_ready = 1 -> IDLE next cycle; the next operation computes correctly.
- Reset mid-RUN:
  - Assert rst_n = 0 after 2 chunks -> outputs 0 asynchronously, state IDLE.
  - After release, 0x12345678 + 0x11111111 -> result = 0x23456789, cout = 0.
